// File: rtl/dmem_arbiter.sv
// Arbitrates one data-memory access per cycle between the processor and a debug/loader port.
// Define ARB_ROUND_ROBIN_EN for round-robin conflict resolution; otherwise the processor has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_DBG} arbState_t;

    arbState_t state;
    arbState_t nextState;
    logic      cpuEligible;
    logic      dbgEligible;
    logic      bothEligible;
`ifdef ARB_ROUND_ROBIN_EN
    logic      preferDbg;
`endif

    // The owner of this cycle's access may not win the next one, so conflicts only arise from IDLE.
    always_comb begin
        cpuEligible  = cpu_req && (state != GNT_CPU);
        dbgEligible  = dbg_req && (state != GNT_DBG);
        bothEligible = cpuEligible && dbgEligible;
        nextState    = IDLE;
        if (bothEligible) begin
`ifdef ARB_ROUND_ROBIN_EN
            nextState = preferDbg ? GNT_DBG : GNT_CPU;
`else
            nextState = GNT_CPU;
`endif
        end else if (cpuEligible) begin
            nextState = GNT_CPU;
        end else if (dbgEligible) begin
            nextState = GNT_DBG;
        end
    end

    assign cpu_rdata = cpu_rvalid ? mem_dout : '0;
    assign dbg_rdata = dbg_rvalid ? mem_dout : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cpu_gnt      <= 1'b0;
            dbg_gnt      <= 1'b0;
            cpu_rvalid   <= 1'b0;
            dbg_rvalid   <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= '0;
            conflict_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            preferDbg    <= 1'b0;
`endif
        end else begin
            state      <= nextState;
            cpu_gnt    <= (nextState == GNT_CPU);
            dbg_gnt    <= (nextState == GNT_DBG);
            // Memory returns read data one cycle after the grant cycle in which it sampled the address.
            cpu_rvalid <= (state == GNT_CPU) && !mem_we;
            dbg_rvalid <= (state == GNT_DBG) && !mem_we;
            case (nextState)
                GNT_CPU: begin
                    mem_we   <= cpu_we;
                    mem_addr <= cpu_addr;
                    mem_din  <= cpu_wdata;
                end
                GNT_DBG: begin
                    mem_we   <= dbg_we;
                    mem_addr <= dbg_addr;
                    mem_din  <= dbg_wdata;
                end
                default: begin
                    mem_we   <= 1'b0;
                end
            endcase
            if (bothEligible && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
`ifdef ARB_ROUND_ROBIN_EN
            if (nextState == GNT_CPU) begin
                preferDbg <= 1'b1;
            end else if (nextState == GNT_DBG) begin
                preferDbg <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_dmem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_BUILD = 1'b1;
`else
    localparam bit RR_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [8:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [8:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic [15:0] conflict_cnt;

    int total = 0;
    int bad = 0;

    dmem_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initVal(int i);
        return (i == 16) ? 32'hDEADBEEF : (32'hA5000000 | 32'(i));
    endfunction

    // Synchronous data memory with registered read, preloaded on its first clock.
    logic [31:0] benchMem [512];
    bit          memLoaded = 1'b0;
    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < 512; i++) benchMem[i] <= initVal(i);
            memLoaded <= 1'b1;
        end else begin
            if (mem_we) benchMem[mem_addr] <= mem_din;
            mem_dout <= benchMem[mem_addr];
        end
    end

    // Transaction-level reference: who owns each cycle, what each grant reads or writes.
    logic [31:0] refMem [512];
    int          owner;
    bit          preferDbg;
    logic [15:0] expCnt;
    bit          expCpuGnt, expDbgGnt, expCpuRv, expDbgRv;
    logic [31:0] expRdata;
    int          pendReadWho;
    logic [31:0] pendVal;
    bit          pendWr;
    logic [8:0]  pendWrAddr;
    logic [31:0] pendWrData;

    function automatic void modelReset();
        owner = 0; preferDbg = 1'b0; expCnt = '0;
        expCpuGnt = 0; expDbgGnt = 0; expCpuRv = 0; expDbgRv = 0; expRdata = '0;
        pendReadWho = 0; pendVal = '0; pendWr = 0; pendWrAddr = '0; pendWrData = '0;
    endfunction

    function automatic void modelEdge();
        bit          cpuE, dbgE, we;
        int          win;
        logic [8:0]  addr;
        logic [31:0] data;
        if (pendWr) refMem[pendWrAddr] = pendWrData;
        expCpuRv = (pendReadWho == 1);
        expDbgRv = (pendReadWho == 2);
        expRdata = pendVal;
        cpuE = cpu_req && (owner != 1);
        dbgE = dbg_req && (owner != 2);
        if (cpuE && dbgE) begin
            if (expCnt != 16'hFFFF) expCnt = expCnt + 16'd1;
            win = (RR_BUILD && preferDbg) ? 2 : 1;
        end else begin
            win = cpuE ? 1 : (dbgE ? 2 : 0);
        end
        if (win != 0) preferDbg = (win == 1);
        we   = (win == 1) ? cpu_we : dbg_we;
        addr = (win == 1) ? cpu_addr : dbg_addr;
        data = (win == 1) ? cpu_wdata : dbg_wdata;
        pendWr      = (win != 0) && we;
        pendWrAddr  = addr;
        pendWrData  = data;
        pendReadWho = (win != 0 && !we) ? win : 0;
        pendVal     = refMem[addr];
        expCpuGnt   = (win == 1);
        expDbgGnt   = (win == 2);
        owner       = win;
    endfunction

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic applyReset();
        cpu_req = 0; dbg_req = 0;
        rst = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin bad++; $display("[TB] FAIL reset_gnt: got %b%b want 00", cpu_gnt, dbg_gnt); end
        total++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid: got %b%b want 00", cpu_rvalid, dbg_rvalid); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_we: got %b want 0", mem_we); end
        total++; if (mem_addr !== 9'h000) begin bad++; $display("[TB] FAIL reset_mem_addr: got %h want 000", mem_addr); end
        total++; if (mem_din !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_din: got %h want 0", mem_din); end
        total++; if (conflict_cnt !== 16'h0) begin bad++; $display("[TB] FAIL reset_conflict_cnt: got %h want 0", conflict_cnt); end
        total++; if ($isunknown(cpu_rdata) || $isunknown(dbg_rdata)) begin bad++; $display("[TB] FAIL reset_rdata_x: got %h/%h want known", cpu_rdata, dbg_rdata); end
        rst = 1'b1;
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        tick();
        total++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin bad++; $display("[TB] FAIL rd_gnt: got %b%b want 10", cpu_gnt, dbg_gnt); end
        total++; if (mem_addr !== 9'h010 || mem_we !== 1'b0) begin bad++; $display("[TB] FAIL rd_mem_addr: got %h we=%b want 010 we=0", mem_addr, mem_we); end
        cpu_req = 0;
        tick();
        total++; if (cpu_gnt !== 1'b0 || cpu_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL rd_rvalid: got gnt=%b rv=%b want 0 1", cpu_gnt, cpu_rvalid); end
        total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL rd_data: got %h want deadbeef", cpu_rdata); end
        total++; if (dbg_gnt !== 1'b0 || dbg_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL rd_dbg_quiet: got %b%b want 00", dbg_gnt, dbg_rvalid); end
        tick();
        total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL rd_rvalid_pulse: got %b want 0", cpu_rvalid); end
    endtask

    task automatic test_write_then_read();
        dbg_req = 1; dbg_we = 1; dbg_addr = 9'h020; dbg_wdata = 32'h12345678;
        tick();
        total++; if (dbg_gnt !== 1'b1 || mem_we !== 1'b1 || mem_din !== 32'h12345678) begin bad++; $display("[TB] FAIL wr_issue: got gnt=%b we=%b din=%h want 1 1 12345678", dbg_gnt, mem_we, mem_din); end
        dbg_req = 0;
        tick();
        total++; if (dbg_rvalid !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("[TB] FAIL wr_no_rvalid: got rv=%b we=%b want 0 0", dbg_rvalid, mem_we); end
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h020;
        tick();
        cpu_req = 0;
        tick();
        total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h12345678) begin bad++; $display("[TB] FAIL wr_readback: got rv=%b data=%h want 1 12345678", cpu_rvalid, cpu_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        int cpuGrants = 0, dbgGrants = 0;
        applyReset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        dbg_req = 1; dbg_we = 0; dbg_addr = 9'h020;
        for (int i = 0; i < 8; i++) begin
            tick();
            cpuGrants += int'(cpu_gnt);
            dbgGrants += int'(dbg_gnt);
            total++; if (cpu_gnt !== (i % 2 == 0) || dbg_gnt !== (i % 2 == 1)) begin bad++; $display("[TB] FAIL b2b_gnt[%0d]: got %b%b want %b%b", i, cpu_gnt, dbg_gnt, i % 2 == 0, i % 2 == 1); end
            if (i > 0) begin
                total++; if (cpu_rvalid !== (i % 2 == 1) || dbg_rvalid !== (i % 2 == 0)) begin bad++; $display("[TB] FAIL b2b_rvalid[%0d]: got %b%b want %b%b", i, cpu_rvalid, dbg_rvalid, i % 2 == 1, i % 2 == 0); end
                total++; if ((i % 2 == 1 ? cpu_rdata : dbg_rdata) !== (i % 2 == 1 ? 32'hDEADBEEF : 32'h12345678)) begin bad++; $display("[TB] FAIL b2b_rdata[%0d]: got %h/%h", i, cpu_rdata, dbg_rdata); end
            end
        end
        total++; if (cpuGrants != 4 || dbgGrants != 4) begin bad++; $display("[TB] FAIL b2b_counts: got %0d/%0d want 4/4", cpuGrants, dbgGrants); end
        total++; if (conflict_cnt !== 16'd1) begin bad++; $display("[TB] FAIL b2b_conflicts: got %0d want 1", conflict_cnt); end
        cpu_req = 0; dbg_req = 0;
        tick();
        tick();
    endtask

    task automatic test_arbitration_start();
        applyReset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        tick();
        cpu_req = 0;
        tick();
        cpu_req = 1; dbg_req = 1; dbg_we = 0; dbg_addr = 9'h020;
        tick();
        total++; if (cpu_gnt !== !RR_BUILD || dbg_gnt !== RR_BUILD) begin bad++; $display("[TB] FAIL arb_first: got %b%b want %b%b", cpu_gnt, dbg_gnt, !RR_BUILD, RR_BUILD); end
        total++; if (conflict_cnt !== 16'd1) begin bad++; $display("[TB] FAIL arb_conflicts: got %0d want 1", conflict_cnt); end
        tick();
        total++; if (cpu_gnt !== RR_BUILD || dbg_gnt !== !RR_BUILD) begin bad++; $display("[TB] FAIL arb_second: got %b%b want %b%b", cpu_gnt, dbg_gnt, RR_BUILD, !RR_BUILD); end
        cpu_req = 0; dbg_req = 0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_write();
        applyReset();
        dbg_req = 1; dbg_we = 1; dbg_addr = 9'h030; dbg_wdata = 32'hCAFEF00D;
        tick();
        dbg_req = 0;
        #2;
        rst = 1'b0;
        modelReset();
        #1;
        total++; if (dbg_gnt !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("[TB] FAIL rstwr_cancel: got gnt=%b we=%b want 0 0", dbg_gnt, mem_we); end
        total++; if (mem_addr !== 9'h0 || mem_din !== 32'h0) begin bad++; $display("[TB] FAIL rstwr_bus: got %h/%h want 0/0", mem_addr, mem_din); end
        @(posedge clk);
        #1;
        total++; if (benchMem[9'h030] !== initVal(48)) begin bad++; $display("[TB] FAIL rstwr_mem: got %h want %h", benchMem[9'h030], initVal(48)); end
        total++; if (dbg_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL rstwr_rvalid: got %b want 0", dbg_rvalid); end
        rst = 1'b1;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            total++; if (cpu_gnt !== expCpuGnt || dbg_gnt !== expDbgGnt) begin bad++; $display("[TB] FAIL rnd_gnt@%0d: got %b%b want %b%b", cyc, cpu_gnt, dbg_gnt, expCpuGnt, expDbgGnt); end
            total++; if (cpu_rvalid !== expCpuRv || dbg_rvalid !== expDbgRv) begin bad++; $display("[TB] FAIL rnd_rvalid@%0d: got %b%b want %b%b", cyc, cpu_rvalid, dbg_rvalid, expCpuRv, expDbgRv); end
            total++; if (conflict_cnt !== expCnt) begin bad++; $display("[TB] FAIL rnd_conflicts@%0d: got %0d want %0d", cyc, conflict_cnt, expCnt); end
            if (expCpuRv) begin
                total++; if (cpu_rdata !== expRdata) begin bad++; $display("[TB] FAIL rnd_cpu_rdata@%0d: got %h want %h", cyc, cpu_rdata, expRdata); end
            end
            if (expDbgRv) begin
                total++; if (dbg_rdata !== expRdata) begin bad++; $display("[TB] FAIL rnd_dbg_rdata@%0d: got %h want %h", cyc, dbg_rdata, expRdata); end
            end
            if (cpu_req && !expCpuGnt) begin
                if ($urandom_range(7) == 0) cpu_req = 0;
            end else if ($urandom_range(1) == 1) begin
                cpu_req = 1; cpu_we = 1'($urandom_range(1));
                cpu_addr = 9'h040 | 9'($urandom_range(15)); cpu_wdata = $urandom;
            end else begin
                cpu_req = 0;
            end
            if (dbg_req && !expDbgGnt) begin
                if ($urandom_range(7) == 0) dbg_req = 0;
            end else if ($urandom_range(1) == 1) begin
                dbg_req = 1; dbg_we = 1'($urandom_range(1));
                dbg_addr = 9'h040 | 9'($urandom_range(15)); dbg_wdata = $urandom;
            end else begin
                dbg_req = 0;
            end
        end
        cpu_req = 0; dbg_req = 0;
        tick();
        tick();
    endtask

    task automatic test_saturation();
        applyReset();
        cpu_we = 0; dbg_we = 0; cpu_addr = 9'h010; dbg_addr = 9'h020;
        for (int i = 1; i <= 65540; i++) begin
            cpu_req = 1; dbg_req = 1;
            tick();
            cpu_req = 0; dbg_req = 0;
            tick();
            if (i == 65534) begin
                total++; if (conflict_cnt !== 16'hFFFE) begin bad++; $display("[TB] FAIL sat_below: got %h want fffe", conflict_cnt); end
            end
            if (i == 65535) begin
                total++; if (conflict_cnt !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_reach: got %h want ffff", conflict_cnt); end
            end
        end
        total++; if (conflict_cnt !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_hold: got %h want ffff", conflict_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) refMem[i] = initVal(i);
        modelReset();
        test_reset();
        test_cpu_read();
        test_write_then_read();
        test_back_to_back();
        test_arbitration_start();
        test_reset_mid_write();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
